// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Requester identities, also used as the tie-break history value
  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  // Memory wait cycles tolerated before an access is declared timed out
  localparam int DEFAULT_MAX_WAIT = 15;

  // Pick the requester to serve; on a tie the one not served last wins
  function automatic logic pick_owner(input logic f_req, input logic d_req,
                                      input logic last_owner);
    logic owner;
    if (f_req && d_req) begin
      owner = ~last_owner;
    end else if (d_req) begin
      owner = OWNER_DATA;
    end else begin
      owner = OWNER_FETCH;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Bounded-wait counter: counts memory stall cycles of one access and flags
// when the allowed number of stall cycles has been used up.
module mem_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_count;

  // Stall counter: cleared between accesses, saturates at the limit
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// load/store. One access at a time: grant in IDLE, hold the latched request
// on the memory bus in BUSY, return a one-cycle response pulse in DONE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                fetch_gnt,
  output logic                fetch_valid,
  output logic [DATA_W-1:0]   fetch_rdata,
  output logic                fetch_err,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_gnt,
  output logic                data_valid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  arb_state_t          r_state;
  logic                r_last_owner;
  logic                r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_fetch_valid;
  logic                r_data_valid;

  logic w_busy;
  logic w_grant;
  logic w_owner;
  logic w_expired;

  assign w_busy  = (r_state == ST_BUSY);
  // Grants only in IDLE and never while reset is being applied
  assign w_grant = rst && (r_state == ST_IDLE) && (fetch_req || data_req);
  assign w_owner = pick_owner(fetch_req, data_req, r_last_owner);

  assign fetch_gnt = w_grant && (w_owner == OWNER_FETCH);
  assign data_gnt  = w_grant && (w_owner == OWNER_DATA);

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!w_busy),
    .enable  (w_busy && !mem_ready),
    .expired (w_expired)
  );

  // Arbiter FSM with request latches and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_last_owner  <= OWNER_FETCH;
      r_owner       <= OWNER_FETCH;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_data_valid  <= 1'b0;
    end else begin
      r_fetch_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner      <= w_owner;
            r_last_owner <= w_owner;
            if (w_owner == OWNER_DATA) begin
              r_we    <= data_we;
              r_addr  <= data_addr;
              r_wdata <= data_wdata;
              r_wstrb <= data_wstrb;
            end else begin
              r_we    <= 1'b0;
              r_addr  <= fetch_addr;
              r_wdata <= '0;
              r_wstrb <= '0;
            end
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A ready on the threshold cycle still counts as success
          if (mem_ready) begin
            r_rdata       <= r_we ? '0 : mem_rdata;
            r_err         <= 1'b0;
            r_fetch_valid <= (r_owner == OWNER_FETCH);
            r_data_valid  <= (r_owner == OWNER_DATA);
            r_state       <= ST_DONE;
          end else if (w_expired) begin
            r_rdata       <= '0;
            r_err         <= 1'b1;
            r_fetch_valid <= (r_owner == OWNER_FETCH);
            r_data_valid  <= (r_owner == OWNER_DATA);
            r_state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = w_busy;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

  // Response is presented only to the owner, and only in its valid cycle
  assign fetch_valid = r_fetch_valid;
  assign fetch_rdata = r_fetch_valid ? r_rdata : '0;
  assign fetch_err   = r_fetch_valid & r_err;
  assign data_valid  = r_data_valid;
  assign data_rdata  = r_data_valid ? r_rdata : '0;
  assign data_err    = r_data_valid & r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scripted requesters, a
// variable-latency memory model and a response scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_gnt, fetch_valid, fetch_err;
  logic [31:0] fetch_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        data_gnt, data_valid, data_err;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  // memory model controls
  int          mem_lat = 0;       // ready on mem_req cycle mem_lat+1; <0 = never
  logic [31:0] mem_data = '0;
  logic        idle_ready = 1'b0; // drive ready while no access is in progress
  int          busy_n = 0;
  int          last_busy_len = 0;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  mem_port_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_rdata (fetch_rdata),
    .fetch_err   (fetch_err),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_wstrb  (data_wstrb),
    .data_gnt    (data_gnt),
    .data_valid  (data_valid),
    .data_rdata  (data_rdata),
    .data_err    (data_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic o, input logic [31:0] d, input logic e);
    exp_t t;
    t.owner = o;
    t.rdata = d;
    t.err   = e;
    exp_q.push_back(t);
  endtask

  // Memory: counts mem_req cycles of the current access, answers per mem_lat
  task automatic mem_model();
    forever begin
      @(negedge clk);
      if (mem_req) begin
        busy_n++;
        if (mem_lat >= 0 && busy_n == mem_lat + 1) begin
          mem_ready = 1'b1;
          mem_rdata = mem_data;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        if (busy_n != 0) last_busy_len = busy_n;
        busy_n    = 0;
        mem_ready = idle_ready;
        mem_rdata = $urandom;
      end
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding expectation
  task automatic monitor();
    exp_t        e;
    logic        g_owner;
    logic [31:0] g_rdata, o_rdata;
    logic        g_err, o_err;
    forever begin
      @(negedge clk);
      if (fetch_valid || data_valid) begin
        checks++;
        if (fetch_valid && data_valid) begin
          errors++;
          $display("FAIL valid_exclusive: fetch_valid=1 data_valid=1, required only one");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: fetch_valid=%0b data_valid=%0b, required no response",
                   fetch_valid, data_valid);
        end else begin
          e       = exp_q.pop_front();
          g_owner = data_valid;
          g_rdata = data_valid ? data_rdata : fetch_rdata;
          g_err   = data_valid ? data_err : fetch_err;
          o_rdata = data_valid ? fetch_rdata : data_rdata;
          o_err   = data_valid ? fetch_err : data_err;
          if (g_owner !== e.owner || g_rdata !== e.rdata || g_err !== e.err ||
              o_rdata !== 32'h0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL response: got owner=%0d rdata=%h err=%0b other=%h/%0b, required owner=%0d rdata=%h err=%0b other=0/0",
                     g_owner, g_rdata, g_err, o_rdata, o_err, e.owner, e.rdata, e.err);
          end else begin
            $display("txn owner=%s rdata=%h err=%0b ok", g_owner ? "DATA" : "FETCH",
                     g_rdata, g_err);
          end
        end
      end
    end
  endtask

  // Wait for the next valid pulse; cycles numbered from first_cyc
  task automatic wait_valid(input int first_cyc, output int seen, output int gnts,
                            output logic mreq);
    seen = -1;
    gnts = 0;
    mreq = 1'bx;
    for (int k = first_cyc; k < first_cyc + 60; k++) begin
      @(negedge clk); #2;
      if (fetch_gnt || data_gnt) gnts++;
      if (fetch_valid || data_valid) begin
        seen = k;
        mreq = mem_req;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h44;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h88; data_wstrb = 4'hF;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (fetch_gnt !== 1'b0 || data_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: fetch_gnt=%b data_gnt=%b, required 0 0", fetch_gnt, data_gnt);
    end
    checks++;
    if (mem_req !== 1'b0 || fetch_valid !== 1'b0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: mem_req=%b fetch_valid=%b data_valid=%b, required 0 0 0",
               mem_req, fetch_valid, data_valid);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: we=%b addr=%h wstrb=%h wdata=%h, required all 0",
               mem_we, mem_addr, mem_wstrb, mem_wdata);
    end
    fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_wstrb = 4'h0;
    rst = 1'b1;
  endtask

  task automatic test_store();
    int seen, gnts;
    logic mreq;
    @(negedge clk); #1;
    mem_lat = 0; mem_data = 32'hFFFF_FFFF;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h200;
    data_wdata = 32'h1234_5678; data_wstrb = 4'b0011;
    #1;
    checks++;
    if (data_gnt !== 1'b1 || fetch_gnt !== 1'b0) begin
      errors++;
      $display("FAIL store_gnt: data_gnt=%b fetch_gnt=%b, required 1 0", data_gnt, fetch_gnt);
    end
    push_exp(1'b1, 32'h0, 1'b0);
    @(negedge clk); #1;
    data_req = 1'b0; data_we = 1'b0; data_addr = 32'hFFF;
    data_wdata = 32'h0; data_wstrb = 4'hF;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b0011 ||
        mem_addr !== 32'h200 || mem_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL store_bus: req=%b we=%b wstrb=%h addr=%h wdata=%h, required 1 1 3 00000200 12345678",
               mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata);
    end
    wait_valid(2, seen, gnts, mreq);
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL store_latency: valid at cycle %0d, required 2", seen);
    end
  endtask

  task automatic test_fetch_read();
    int seen, gnts;
    logic mreq;
    @(negedge clk); #1;
    mem_lat = 1; mem_data = 32'hDEAD_BEEF;
    fetch_req = 1'b1; fetch_addr = 32'h100;
    #1;
    checks++;
    if (fetch_gnt !== 1'b1 || data_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gnt: fetch_gnt=%b data_gnt=%b, required 1 0", fetch_gnt, data_gnt);
    end
    push_exp(1'b0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk); #1;
    fetch_req = 1'b0; fetch_addr = 32'h0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_wstrb !== 4'h0 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL fetch_bus: req=%b we=%b wstrb=%h addr=%h, required 1 0 0 00000100",
               mem_req, mem_we, mem_wstrb, mem_addr);
    end
    wait_valid(2, seen, gnts, mreq);
    checks++;
    if (seen != 3 || gnts != 0) begin
      errors++;
      $display("FAIL fetch_latency: valid at cycle %0d with %0d grants, required cycle 3, 0 grants",
               seen, gnts);
    end
  endtask

  task automatic test_back_to_back();
    int   n, seen, gnts;
    logic mreq;
    bit   both;
    bit   order_v [0:3];
    do_reset();
    mem_lat = 0;
    fetch_req = 1'b1; fetch_addr = 32'h1000;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h2000;
    n = 0; both = 1'b0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      #1;
      if (fetch_gnt && data_gnt) both = 1'b1;
      if (fetch_gnt || data_gnt) begin
        order_v[n] = data_gnt;
        mem_data = 32'hC0DE_0000 + 32'(n);
        push_exp(data_gnt, mem_data, 1'b0);
        n++;
      end
      @(negedge clk); #1;
    end
    fetch_req = 1'b0; data_req = 1'b0;
    wait_valid(2, seen, gnts, mreq);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL tie_count: %0d grants, required 4", n);
    end else begin
      checks++;
      if (order_v[0] !== 1'b1 || order_v[1] !== 1'b0 || order_v[2] !== 1'b1 || order_v[3] !== 1'b0) begin
        errors++;
        $display("FAIL tie_order: got %0d%0d%0d%0d (1=DATA), required 1010",
                 order_v[0], order_v[1], order_v[2], order_v[3]);
      end
    end
    checks++;
    if (both) begin
      errors++;
      $display("FAIL tie_exclusive: both grants seen in one cycle, required never");
    end
  endtask

  task automatic test_timeout();
    int   seen, gnts;
    logic mreq;
    @(negedge clk); #1;
    mem_lat = -1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h300;
    #1;
    checks++;
    if (data_gnt !== 1'b1) begin
      errors++;
      $display("FAIL timeout_gnt: data_gnt=%b, required 1", data_gnt);
    end
    push_exp(1'b1, 32'h0, 1'b1);
    @(negedge clk); #1;
    data_req = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h400;
    wait_valid(2, seen, gnts, mreq);
    checks++;
    if (seen != 17 || mreq !== 1'b0) begin
      errors++;
      $display("FAIL timeout_latency: valid at cycle %0d mem_req=%b, required cycle 17 mem_req=0",
               seen, mreq);
    end
    checks++;
    if (last_busy_len != 16 || gnts != 0) begin
      errors++;
      $display("FAIL timeout_busy: mem_req cycles=%0d grants=%0d, required 16 and 0",
               last_busy_len, gnts);
    end
    mem_lat = 0; mem_data = 32'h0BAD_F00D;
    @(negedge clk); #2;
    checks++;
    if (fetch_gnt !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next_gnt: fetch_gnt=%b, required 1", fetch_gnt);
    end
    push_exp(1'b0, 32'h0BAD_F00D, 1'b0);
    wait_valid(1, seen, gnts, mreq);
    fetch_req = 1'b0;
    checks++;
    if (seen != 2 || gnts != 0) begin
      errors++;
      $display("FAIL timeout_next_latency: valid at cycle %0d grants=%0d, required 2 and 0",
               seen, gnts);
    end
  endtask

  task automatic test_ready_on_threshold();
    int   seen, gnts;
    logic mreq;
    idle_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    mem_lat = 15; mem_data = 32'h5A5A_1234;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h500;
    #1;
    checks++;
    if (data_gnt !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL thresh_gnt: data_gnt=%b mem_req=%b, required 1 0", data_gnt, mem_req);
    end
    push_exp(1'b1, 32'h5A5A_1234, 1'b0);
    @(negedge clk); #1;
    data_req = 1'b0;
    wait_valid(2, seen, gnts, mreq);
    checks++;
    if (seen != 17) begin
      errors++;
      $display("FAIL thresh_latency: valid at cycle %0d, required 17", seen);
    end
    idle_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int   seen, gnts, nvalid;
    logic mreq;
    @(negedge clk); #1;
    mem_lat = -1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h600;
    #1;
    checks++;
    if (data_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_gnt: data_gnt=%b, required 1", data_gnt);
    end
    @(negedge clk); #1;
    data_req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #2;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_mem_req: mem_req=%b after reset edge, required 0", mem_req);
    end
    rst = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #2;
      if (fetch_valid || data_valid) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL abort_no_valid: %0d valid pulses, required 0", nvalid);
    end
    mem_lat = 0; mem_data = 32'h600D_CAFE;
    fetch_req = 1'b1; fetch_addr = 32'h700;
    data_req = 1'b1; data_addr = 32'h800;
    #1;
    checks++;
    if (data_gnt !== 1'b1 || fetch_gnt !== 1'b0) begin
      errors++;
      $display("FAIL abort_tie: data_gnt=%b fetch_gnt=%b, required 1 0", data_gnt, fetch_gnt);
    end
    push_exp(1'b1, 32'h600D_CAFE, 1'b0);
    @(negedge clk); #1;
    fetch_req = 1'b0; data_req = 1'b0;
    wait_valid(2, seen, gnts, mreq);
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL abort_next_latency: valid at cycle %0d, required 2", seen);
    end
  endtask

  initial begin
    fork
      mem_model();
      monitor();
    join_none
    test_reset();
    test_store();
    test_fetch_read();
    test_back_to_back();
    test_timeout();
    test_ready_on_threshold();
    test_reset_mid_busy();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
